// File: rtl/serial_add_sub.sv
// ---------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial two's-complement adder/subtractor. Two WIDTH-bit operands and
//   an add/sub select are latched on a start request. One bit pair per clock
//   then goes through a single add_sub cell, LSB first. The cell's carry is
//   held in a flop between bits, and the sum bits are shifted into the result
//   register from the top. After WIDTH bit-cycles the block presents the full
//   result, the carry out of the MSB and the signed overflow flag.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : begin an operation (only honoured while idle)
//   a, b     : operands (a - b when sel=1)
//   sel      : 0 = add, 1 = subtract
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when result/cout/overflow become valid
//   result   : sum or difference, valid while busy is low
//   cout     : carry out of the MSB (1 = no borrow for subtraction)
//   overflow : signed overflow of the last operation
// ---------------------------------------------------------------------------

// Single-bit full adder with b conditionally inverted. When sel=1 the cell
// adds ~b, and the sequencer supplies the +1 through the initial carry.
module add_sub (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sel,
    output logic sum,
    output logic cout
);
    logic w_b;

    assign w_b  = b ^ sel;
    assign sum  = a ^ w_b ^ cin;
    assign cout = (a & w_b) | (a & cin) | (w_b & cin);
endmodule

module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_op;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_overflow;
    logic             r_done;

    logic             w_sum;
    logic             w_cout;

    // The only combinational path: operand LSBs and carry flop through the
    // cell into the carry flop and the result MSB.
    add_sub u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .sel  (r_op),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Sequencer: load operands on start, then process one bit per clock.
    // On the last bit the carry flop still holds the carry into the MSB and
    // the cell produces the carry out of it, so their XOR is signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_op       <= 1'b0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_op    <= sel;
                        // Initial carry of 1 completes ~b + 1 for subtraction.
                        r_carry <= sel;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_result <= {w_sum, r_result[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_cout     <= w_cout;
                        r_overflow <= r_carry ^ w_cout;
                        r_done     <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = r_done;
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_overflow;
endmodule
